// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, latency and saturation helper for the conv engines
package conv_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_IN_CH       = 16;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_BIAS_WIDTH  = 32;
    localparam int DEF_SCALE_WIDTH = 16;
    localparam int DEF_OUT_WIDTH   = 8;

    localparam int CONV33_LAT = 5;
    localparam int K33        = 9;

    // Clamp a signed value into the range of a signed field of the given width.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/conv33_ch_acc_if.sv
// rtl/conv33_ch_acc_if.sv - beat/sideband inputs and pixel output of the 3x3 channel accumulator
interface conv33_ch_acc_if #(
    parameter int DATA_WIDTH  = conv_pkg::DEF_DATA_WIDTH,
    parameter int IN_CH       = conv_pkg::DEF_IN_CH,
    parameter int BIAS_WIDTH  = conv_pkg::DEF_BIAS_WIDTH,
    parameter int SCALE_WIDTH = conv_pkg::DEF_SCALE_WIDTH,
    parameter int OUT_WIDTH   = conv_pkg::DEF_OUT_WIDTH
);
    localparam int CW = $clog2(IN_CH) + 1;

    logic                              clear;
    logic                              in_valid;
    logic [conv_pkg::K33*DATA_WIDTH-1:0] window;
    logic [conv_pkg::K33*DATA_WIDTH-1:0] weights;
    logic signed [BIAS_WIDTH-1:0]      bias;
    logic signed [SCALE_WIDTH-1:0]     scale;
    logic [5:0]                        shift;
    logic                              relu_en;
    logic [CW-1:0]                     ch_idx;
    logic                              out_valid;
    logic signed [OUT_WIDTH-1:0]       result;

    modport master (
        output clear, in_valid, window, weights, bias, scale, shift, relu_en,
        input  ch_idx, out_valid, result
    );

    modport slave (
        input  clear, in_valid, window, weights, bias, scale, shift, relu_en,
        output ch_idx, out_valid, result
    );
endinterface

// File: rtl/conv33_requant.sv
// rtl/conv33_requant.sv - scale multiply, round-half-up shift, ReLU and saturate with valid pipeline
module conv33_requant
    import conv_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [ACC_WIDTH-1:0]   in_value,
    input  logic signed [SCALE_WIDTH-1:0] scale,
    input  logic [5:0]                    shift,
    input  logic                          relu_en,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   result
);
    localparam int PW = ACC_WIDTH + SCALE_WIDTH;

    logic signed [PW-1:0]        prod_q, prod_d;
    logic                        va_q, va_d, relu_a_q, relu_a_d;
    logic [5:0]                  shift_a_q, shift_a_d;
    logic signed [PW:0]          rnd_q, rnd_d, rnd_add, pre_shift, relu_val;
    logic                        vb_q, vb_d, relu_b_q, relu_b_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0] result_q, result_d;
    logic signed [63:0]          sat_val;

    always_comb begin
        prod_d    = PW'(in_value) * PW'(scale);
        va_d      = in_valid;
        shift_a_d = shift;
        relu_a_d  = relu_en;

        // One extra bit of headroom so the rounding add cannot wrap.
        rnd_add   = (shift_a_q != 6'd0) ? ((PW+1)'(1) << (shift_a_q - 6'd1)) : '0;
        pre_shift = (PW+1)'(prod_q) + rnd_add;
        rnd_d     = pre_shift >>> shift_a_q;
        vb_d      = va_q;
        relu_b_d  = relu_a_q;

        relu_val    = (relu_b_q && rnd_q[PW]) ? '0 : rnd_q;
        sat_val     = sat_signed(64'(relu_val), OUT_WIDTH);
        out_valid_d = vb_q;
        result_d    = vb_q ? sat_val[OUT_WIDTH-1:0] : result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= '0;
            va_q        <= 1'b0;
            shift_a_q   <= '0;
            relu_a_q    <= 1'b0;
            rnd_q       <= '0;
            vb_q        <= 1'b0;
            relu_b_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            prod_q      <= prod_d;
            va_q        <= va_d;
            shift_a_q   <= shift_a_d;
            relu_a_q    <= relu_a_d;
            rnd_q       <= rnd_d;
            vb_q        <= vb_d;
            relu_b_q    <= relu_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: rtl/conv33_ch_acc.sv
// rtl/conv33_ch_acc.sv - multi-channel 3x3 conv: products, adder tree, channel accumulate, bias, requant
module conv33_ch_acc
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int IN_CH       = DEF_IN_CH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int BIAS_WIDTH  = DEF_BIAS_WIDTH,
    parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    conv33_ch_acc_if.slave bus
);
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int TW  = 2 * DATA_WIDTH + 4;
    localparam int CW  = $clog2(IN_CH) + 1;
    localparam int SBW = BIAS_WIDTH + SCALE_WIDTH + 7;
    localparam logic [CW-1:0] LAST_CH = CW'(IN_CH - 1);

    logic [CW-1:0]                ch_idx_q, ch_idx_d, ch_eff;
    logic                         last_in;
    logic signed [PW-1:0]         prod_q [K33];
    logic signed [PW-1:0]         prod_d [K33];
    logic                         v1_q, v1_d, last1_q, last1_d;
    logic                         v2_q, v2_d, last2_q, last2_d;
    logic [SBW-1:0]               sb_in, sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;
    logic signed [TW-1:0]         sum_q, sum_d;
    logic signed [BIAS_WIDTH-1:0] bias2;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_plus, s_q, s_d;
    logic                         s_valid_q, s_valid_d;

    always_comb begin
        // A clear in the same cycle as a beat makes that beat channel 0.
        ch_eff   = bus.clear ? '0 : ch_idx_q;
        last_in  = (ch_eff == LAST_CH);
        ch_idx_d = ch_eff;
        if (bus.in_valid) ch_idx_d = last_in ? '0 : ch_eff + CW'(1);

        sb_in = {bus.bias, bus.scale, bus.shift, bus.relu_en};
        for (int k = 0; k < K33; k++) begin
            prod_d[k] = PW'($signed(bus.window[k*DATA_WIDTH +: DATA_WIDTH]))
                      * PW'($signed(bus.weights[k*DATA_WIDTH +: DATA_WIDTH]));
        end
        v1_d    = bus.in_valid;
        last1_d = bus.in_valid && last_in;
        sb1_d   = (bus.in_valid && last_in) ? sb_in : sb1_q;

        sum_d = '0;
        for (int k = 0; k < K33; k++) sum_d = sum_d + TW'(prod_q[k]);
        v2_d    = v1_q && !bus.clear;
        last2_d = last1_q;
        sb2_d   = sb1_q;

        bias2     = $signed(sb2_q[SBW-1 -: BIAS_WIDTH]);
        acc_plus  = acc_q + ACC_WIDTH'(sum_q);
        acc_d     = acc_q;
        s_d       = s_q;
        s_valid_d = 1'b0;
        sb3_d     = sb3_q;
        if (bus.clear) begin
            acc_d = '0;
        end else if (v2_q) begin
            if (last2_q) begin
                acc_d     = '0;
                s_d       = acc_plus + ACC_WIDTH'(bias2);
                s_valid_d = 1'b1;
                sb3_d     = sb2_q;
            end else begin
                acc_d = acc_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx_q  <= '0;
            prod_q    <= '{default: '0};
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            sb1_q     <= '0;
            sum_q     <= '0;
            v2_q      <= 1'b0;
            last2_q   <= 1'b0;
            sb2_q     <= '0;
            acc_q     <= '0;
            s_q       <= '0;
            s_valid_q <= 1'b0;
            sb3_q     <= '0;
        end else begin
            ch_idx_q  <= ch_idx_d;
            prod_q    <= prod_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            sb1_q     <= sb1_d;
            sum_q     <= sum_d;
            v2_q      <= v2_d;
            last2_q   <= last2_d;
            sb2_q     <= sb2_d;
            acc_q     <= acc_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            sb3_q     <= sb3_d;
        end
    end

    assign bus.ch_idx = ch_idx_q;

    conv33_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .SCALE_WIDTH(SCALE_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_requant (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_valid_q),
        .in_value (s_q),
        .scale    ($signed(sb3_q[7 +: SCALE_WIDTH])),
        .shift    (sb3_q[6:1]),
        .relu_en  (sb3_q[0]),
        .out_valid(bus.out_valid),
        .result   (bus.result)
    );
endmodule

// File: tb/tb_conv33_ch_acc.sv
// tb/tb_conv33_ch_acc.sv - directed table and sequence checks for conv33_ch_acc
module tb_conv33_ch_acc;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv33_ch_acc_if #(.IN_CH(1)) if1 ();
    conv33_ch_acc_if #(.IN_CH(4)) if4 ();

    conv33_ch_acc #(.IN_CH(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
    conv33_ch_acc #(.IN_CH(4)) d4 (.clk(clk), .rst(rst), .bus(if4));

    int checks = 0;
    int errors = 0;
    int q1_val[$], q1_cyc[$], q4_val[$], q4_cyc[$];

    always @(negedge clk) begin
        if (if1.out_valid) begin
            q1_val.push_back(int'(if1.result));
            q1_cyc.push_back(cyc);
        end
        if (if4.out_valid) begin
            q4_val.push_back(int'(if4.result));
            q4_cyc.push_back(cyc);
        end
    end

    typedef struct {
        int tap, wt, bias, scale, shift, relu, exp;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack(input int t);
        logic [71:0] v;
        logic [7:0]  b;
        b = 8'(t);
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = b;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat1(input int t, w, b, sc, sh, rl, output int stamp);
        if1.window   = pack(t);
        if1.weights  = pack(w);
        if1.bias     = b;
        if1.scale    = 16'(sc);
        if1.shift    = 6'(sh);
        if1.relu_en  = rl[0];
        if1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        stamp        = cyc;
        if1.in_valid = 1'b0;
    endtask

    task automatic beat4(input int t, w, b, sc, sh, rl, input bit clr, output int stamp);
        if4.window   = pack(t);
        if4.weights  = pack(w);
        if4.bias     = b;
        if4.scale    = 16'(sc);
        if4.shift    = 6'(sh);
        if4.relu_en  = rl[0];
        if4.clear    = clr;
        if4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        stamp        = cyc;
        if4.in_valid = 1'b0;
        if4.clear    = 1'b0;
        if4.bias     = 12345;
        if4.scale    = 16'sd77;
        if4.shift    = 6'd9;
    endtask

    // Group of 4 beats: taps 2, weights 3, sideband only meaningful on the last beat -> 100.
    task automatic group_a(output int last_stamp);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) beat4(2, 3, -16, 1, 1, 0, 1'b0, last_stamp);
            else        beat4(2, 3, 999, 5, 3, 1, 1'b0, last_stamp);
        end
    endtask

    initial begin
        int st, st2;
        vecs[0] = '{1, 1, 0, 1, 0, 0, 9};
        vecs[1] = '{10, 10, 100, 1, 0, 0, 127};
        vecs[2] = '{-10, 10, -100, 1, 0, 0, -128};
        vecs[3] = '{-10, 10, -100, 1, 0, 1, 0};
        vecs[4] = '{0, 0, 5, 1, 1, 0, 3};
        vecs[5] = '{0, 0, -5, 1, 1, 0, -2};
        vecs[6] = '{0, 0, 4, 1, 1, 0, 2};
        vecs[7] = '{3, -4, 10, 3, 2, 0, -73};
        vecs[8] = '{127, 127, 0, 1, 8, 0, 127};
        vecs[9] = '{2, 2, 0, -1, 0, 0, -36};

        if1.clear = 1'b0; if1.in_valid = 1'b0; if1.window = '0; if1.weights = '0;
        if1.bias = '0; if1.scale = '0; if1.shift = '0; if1.relu_en = 1'b0;
        if4.clear = 1'b0; if4.in_valid = 1'b0; if4.window = '0; if4.weights = '0;
        if4.bias = '0; if4.scale = '0; if4.shift = '0; if4.relu_en = 1'b0;

        idle(3);
        chk("rst_ch_idx", int'(if4.ch_idx), 0);
        chk("rst_out_valid4", int'(if4.out_valid), 0);
        chk("rst_result4", int'(if4.result), 0);
        chk("rst_out_valid1", int'(if1.out_valid), 0);
        chk("rst_result1", int'(if1.result), 0);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 10; i++) begin
            q1_val.delete(); q1_cyc.delete();
            beat1(vecs[i].tap, vecs[i].wt, vecs[i].bias, vecs[i].scale,
                  vecs[i].shift, vecs[i].relu, st);
            idle(8);
            chk($sformatf("vec%0d_count", i), q1_val.size(), 1);
            if (q1_val.size() > 0) begin
                chk($sformatf("vec%0d_result", i), q1_val[0], vecs[i].exp);
                chk($sformatf("vec%0d_latency", i), q1_cyc[0] - st, CONV33_LAT);
            end
        end
        chk("in_ch1_ch_idx", int'(if1.ch_idx), 0);

        q4_val.delete(); q4_cyc.delete();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("seq_ch_idx%0d", b), int'(if4.ch_idx), b);
            if (b == 3) beat4(2, 3, -16, 1, 1, 0, 1'b0, st);
            else        beat4(2, 3, 999, 5, 3, 1, 1'b0, st);
        end
        chk("seq_ch_idx_wrap", int'(if4.ch_idx), 0);
        idle(8);
        chk("grp_count", q4_val.size(), 1);
        if (q4_val.size() > 0) begin
            chk("grp_result", q4_val[0], 100);
            chk("grp_latency", q4_cyc[0] - st, CONV33_LAT);
        end
        chk("grp_result_hold", int'(if4.result), 100);

        q4_val.delete(); q4_cyc.delete();
        group_a(st);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) beat4(1, 1, 0, 2, 0, 0, 1'b0, st2);
            else        beat4(1, 1, -7, 9, 4, 1, 1'b0, st2);
        end
        idle(8);
        chk("b2b_count", q4_val.size(), 2);
        if (q4_val.size() == 2) begin
            chk("b2b_result0", q4_val[0], 100);
            chk("b2b_result1", q4_val[1], 72);
            chk("b2b_spacing", q4_cyc[1] - q4_cyc[0], 4);
            chk("b2b_latency", q4_cyc[0] - st, CONV33_LAT);
        end

        q4_val.delete(); q4_cyc.delete();
        beat4(1, 1, 500, 1, 0, 0, 1'b0, st);
        idle($urandom_range(1, 2));
        beat4(1, 1, 500, 1, 0, 0, 1'b0, st);
        chk("clr_pre_ch_idx", int'(if4.ch_idx), 2);
        beat4(2, 1, 500, 3, 2, 1, 1'b1, st);
        chk("clr_post_ch_idx", int'(if4.ch_idx), 1);
        for (int b = 1; b < 4; b++) begin
            idle($urandom_range(0, 2));
            if (b == 3) beat4(2, 1, 0, 1, 0, 0, 1'b0, st);
            else        beat4(2, 1, 500, 3, 2, 1, 1'b0, st);
        end
        idle(8);
        chk("clr_count", q4_val.size(), 1);
        if (q4_val.size() > 0) chk("clr_result", q4_val[0], 72);

        q4_val.delete(); q4_cyc.delete();
        group_a(st);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(8);
        chk("mid_rst_count", q4_val.size(), 0);
        chk("mid_rst_result", int'(if4.result), 0);
        chk("mid_rst_ch_idx", int'(if4.ch_idx), 0);
        group_a(st);
        idle(8);
        chk("post_rst_count", q4_val.size(), 1);
        if (q4_val.size() > 0) chk("post_rst_result", q4_val[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
